hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning performance-counter width.
REQ-003 SHALL have clk, input, 1, the single clock; rising-edge only.
REQ-004 SHALL have rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have id_rs1, id_rs2, input, RA_W each: decode-stage source registers.
REQ-006 SHALL have id_use_rs1, id_use_rs2, input, 1 each: the ID instruction reads that source.
REQ-007 SHALL have ex_rs1, ex_rs2, ex_rd, input, RA_W each: EX-stage register addresses.
REQ-008 SHALL have ex_reg_write and ex_mem_read, input, 1 each: EX writes rd / EX is a load.
REQ-009 SHALL have mem_rd, input, RA_W, and mem_reg_write, input, 1: MEM-stage destination.
REQ-010 SHALL have wb_rd, input, RA_W, and wb_reg_write, input, 1: WB-stage destination.
REQ-011 SHALL have ex_branch_taken, input, 1: taken branch or jump resolved in EX.
REQ-012 SHALL have dmem_busy, input, 1: data memory not ready; the whole pipeline holds.
REQ-013 SHALL have pc_we and if_id_we, output, 1 each: PC and IF/ID register write enables.
REQ-014 SHALL have if_id_flush and id_ex_flush, output, 1 each: insert a bubble into that register.
REQ-015 SHALL have freeze, output, 1: holds the ID/EX, EX/MEM and MEM/WB registers.
REQ-016 SHALL have fwd_a and fwd_b, output, 2 each: ALU operand source; 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-017 SHALL have stall_cnt and flush_cnt, output, CNT_W each: saturating event counters.

Function
REQ-018 SHALL implement FSM states RUN, FROZEN and FLUSH_PEND.
REQ-019 RUN: if dmem_busy=1 and ex_branch_taken=1, go to FLUSH_PEND; if only dmem_busy=1, go to FROZEN.
REQ-020 FROZEN: ex_branch_taken=1 goes to FLUSH_PEND; dmem_busy=0 with no branch goes to RUN.
REQ-021 FLUSH_PEND: stay while dmem_busy=1; on the first cycle with dmem_busy=0, apply the flush and go to RUN.
REQ-022 While dmem_busy=1: freeze=1, pc_we=0, if_id_we=0, both flushes=0; the freeze condition is combinational on dmem_busy.
REQ-023 Flush condition = (ex_branch_taken & !dmem_busy) | (state==FLUSH_PEND & !dmem_busy); on flush: if_id_flush=1, id_ex_flush=1, pc_we=1, if_id_we=1.
REQ-024 A register match SHALL require a destination address != 0; register x0 never produces a hazard.
REQ-025 Data stall: pc_we=0, if_id_we=0, id_ex_flush=1, if_id_flush=0.
REQ-026 Priority SHALL be freeze > flush > data stall > normal operation; a flush squashes a pending stall in the same cycle.
REQ-027 Normal operation: pc_we=1, if_id_we=1, both flushes=0, freeze=0.
REQ-028 Forwarding SHALL select EX/MEM (mem_rd) over MEM/WB (wb_rd) when both match the EX-stage source.
REQ-029 stall_cnt SHALL increment once per data-stall cycle and hold at all-ones.
REQ-030 flush_cnt SHALL increment once per applied flush and hold at all-ones.
REQ-031 Frozen cycles SHALL increment neither counter.

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately force state=RUN, clear the pending flush and zero both counters.
REQ-033 While rst_n=0: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_flush=1, freeze=0, fwd_a=fwd_b=00.
REQ-034 Reset during FROZEN or FLUSH_PEND SHALL discard the pending flush; no flush is applied after release.

Configuration
REQ-035 With macro HAZARD_FORWARDING_EN defined: data stall = ex_mem_read & ex_rd matches a used ID source; the stall lasts 1 cycle; fwd_a/fwd_b are active.
REQ-036 With macro HAZARD_FORWARDING_EN undefined: data stall = a used ID source matches ex_rd (with ex_reg_write) or mem_rd (with mem_reg_write); fwd_a/fwd_b are tied to 00; the regfile is write-through, so WB never stalls.

Structure
REQ-037 Package hazard_pkg SHALL hold the FSM state enum, the FWD_REG/FWD_EXMEM/FWD_MEMWB constants and RA_W.
REQ-038 A sub-module sat_counter (width parameter, inc input, saturating) SHALL be instantiated twice.

Verification
REQ-039 Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID add uses rs1=5, forwarding on -> one cycle with pc_we=0 and id_ex_flush=1; stall_cnt=1.
REQ-040 Without forwarding: ex_rd=7, ex_reg_write=1, ID uses rs2=7 -> 2 stall cycles as rd moves EX->MEM->WB; stall_cnt=2.
REQ-041 Branch during busy: dmem_busy=1 for 3 cycles, ex_branch_taken=1 in cycle 1 -> freeze=1 for 3 cycles, flushes applied on cycle 4 only; flush_cnt=1.
REQ-042 x0 case: ex_rd=0, ex_mem_read=1, ID rs1=0 -> no stall; with mem_rd=3 and wb_rd=3 matching ex_rs1=3 -> fwd_a=10.
REQ-043 Reset in FLUSH_PEND: drop rst_n for 1 cycle -> no flush after release; both counters 0.
REQ-044 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding-select encodings match the ALU operand mux in the datapath.
package hazard_pkg;

   localparam int RA_W = 5;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_FROZEN     = 2'd1,
      ST_FLUSH_PEND = 2'd2
   } state_t;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register addresses in, stall/flush/forward controls out.
// master = pipeline side, slave = hazard_ctrl side.
interface hazard_ctrl_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
);
   logic [RA_W-1:0]  id_rs1;
   logic [RA_W-1:0]  id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [RA_W-1:0]  ex_rs1;
   logic [RA_W-1:0]  ex_rs2;
   logic [RA_W-1:0]  ex_rd;
   logic             ex_reg_write;
   logic             ex_mem_read;
   logic [RA_W-1:0]  mem_rd;
   logic             mem_reg_write;
   logic [RA_W-1:0]  wb_rd;
   logic             wb_reg_write;
   logic             ex_branch_taken;
   logic             dmem_busy;

   logic             pc_we;
   logic             if_id_we;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             freeze;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             ex_branch_taken, dmem_busy,
      input  pc_we, if_id_we, if_id_flush, id_ex_flush, freeze,
             fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             ex_branch_taken, dmem_busy,
      output pc_we, if_id_we, if_id_flush, id_ex_flush, freeze,
             fwd_a, fwd_b, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: +1 per cycle with inc high, sticks at all-ones.
// Value visible the cycle after the increment; async active-low clear.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze on dmem_busy, deferred branch flush, data-hazard stall, forwarding.
// Controls are combinational on the current inputs; HAZARD_FORWARDING_EN selects forwarding vs full-stall mode.
module hazard_ctrl #(
   parameter int RA_W  = hazard_pkg::RA_W,
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   hazard_ctrl_if.slave hif
);
   import hazard_pkg::*;

   state_t           state_d;
   state_t           state_q;
   logic             busy;
   logic             br;
   logic             data_hzd;
   logic             flush_now;
   logic             stall_now;
   logic [1:0]       fwd_a_raw;
   logic [1:0]       fwd_b_raw;
   logic [CNT_W-1:0] stall_cnt_w;
   logic [CNT_W-1:0] flush_cnt_w;

   assign busy = hif.dmem_busy;
   assign br   = hif.ex_branch_taken;

   // x0 is hardwired zero, so a write to it can never create a dependency.
   function automatic logic src_hit(input logic [RA_W-1:0] src, input logic use_src,
                                    input logic [RA_W-1:0] dst, input logic dst_we);
      return use_src & dst_we & (dst != '0) & (src == dst);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
      if (src_hit(src, 1'b1, hif.mem_rd, hif.mem_reg_write))
         return FWD_EXMEM;
      else if (src_hit(src, 1'b1, hif.wb_rd, hif.wb_reg_write))
         return FWD_MEMWB;
      else
         return FWD_REG;
   endfunction

`ifdef HAZARD_FORWARDING_EN
   // Only a load in EX cannot be forwarded in time; everything else bypasses.
   assign data_hzd  = src_hit(hif.id_rs1, hif.id_use_rs1, hif.ex_rd, hif.ex_mem_read)
                    | src_hit(hif.id_rs2, hif.id_use_rs2, hif.ex_rd, hif.ex_mem_read);
   assign fwd_a_raw = fwd_sel(hif.ex_rs1);
   assign fwd_b_raw = fwd_sel(hif.ex_rs2);
`else
   // Write-through regfile covers WB; EX and MEM producers must drain first.
   assign data_hzd  = src_hit(hif.id_rs1, hif.id_use_rs1, hif.ex_rd,  hif.ex_reg_write)
                    | src_hit(hif.id_rs2, hif.id_use_rs2, hif.ex_rd,  hif.ex_reg_write)
                    | src_hit(hif.id_rs1, hif.id_use_rs1, hif.mem_rd, hif.mem_reg_write)
                    | src_hit(hif.id_rs2, hif.id_use_rs2, hif.mem_rd, hif.mem_reg_write);
   assign fwd_a_raw = FWD_REG;
   assign fwd_b_raw = FWD_REG;
`endif

   assign flush_now = !busy & (br | (state_q == ST_FLUSH_PEND));
   assign stall_now = !busy & !flush_now & data_hzd;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (busy)
               state_d = br ? ST_FLUSH_PEND : ST_FROZEN;
         end
         ST_FROZEN: begin
            // A branch seen with memory ready is flushed at once, so nothing is left pending.
            if (busy && br)
               state_d = ST_FLUSH_PEND;
            else if (!busy)
               state_d = ST_RUN;
         end
         ST_FLUSH_PEND: begin
            if (!busy)
               state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      hif.pc_we       = 1'b1;
      hif.if_id_we    = 1'b1;
      hif.if_id_flush = 1'b0;
      hif.id_ex_flush = 1'b0;
      hif.freeze      = 1'b0;
      hif.fwd_a       = fwd_a_raw;
      hif.fwd_b       = fwd_b_raw;
      if (!rst_n) begin
         hif.pc_we       = 1'b0;
         hif.if_id_we    = 1'b0;
         hif.if_id_flush = 1'b1;
         hif.id_ex_flush = 1'b1;
         hif.fwd_a       = FWD_REG;
         hif.fwd_b       = FWD_REG;
      end else if (busy) begin
         hif.freeze      = 1'b1;
         hif.pc_we       = 1'b0;
         hif.if_id_we    = 1'b0;
      end else if (flush_now) begin
         hif.if_id_flush = 1'b1;
         hif.id_ex_flush = 1'b1;
      end else if (stall_now) begin
         hif.pc_we       = 1'b0;
         hif.if_id_we    = 1'b0;
         hif.id_ex_flush = 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_now),
      .cnt   (stall_cnt_w)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_now),
      .cnt   (flush_cnt_w)
   );

   assign hif.stall_cnt = stall_cnt_w;
   assign hif.flush_cnt = flush_cnt_w;

endmodule
